// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: NPC op codes, reset vector, FIFO payload and redirect target resolution.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam logic [2:0] NPC_PC4 = 3'b000;
    localparam logic [2:0] NPC_B   = 3'b010;
    localparam logic [2:0] NPC_J   = 3'b011;
    localparam logic [2:0] NPC_JR  = 3'b100;

    typedef struct packed {
        logic            adel;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic            adel;
        logic [XLEN-1:0] pc;
    } fetch_tag_t;

    typedef struct packed {
        logic            take;
        logic            adel;
        logic [XLEN-1:0] target;
    } redir_t;

    // Resolve a redirect command into {take, adel, target}.
    function automatic redir_t npc_resolve(input logic [2:0]      op,
                                           input logic [XLEN-1:0] pc,
                                           input logic [XLEN-1:0] imm,
                                           input logic [XLEN-1:0] rs,
                                           input logic            taken);
        redir_t          r;
        logic [XLEN-1:0] pc4;
        r   = '0;
        pc4 = pc + 32'd4;
        case (op)
            NPC_B: begin
                if (taken) begin
                    r.take   = 1'b1;
                    r.target = pc4 + {imm[29:0], 2'b00};
                end
            end
            NPC_J: begin
                r.take   = 1'b1;
                r.target = {pc4[31:28], imm[25:0], 2'b00};
            end
            NPC_JR: begin
                r.take   = 1'b1;
                r.target = {rs[31:2], 2'b00};
                r.adel   = |rs[1:0];
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// First-word-fall-through fetch buffer holding {adel, pc, inst}; flush dominates push/pop.
module ifetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           data_i,
    input  logic                   pop_i,
    output fetch_entry_t           data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, credit-limited in-order memory reads, tag queue,
// discard tracking for flushed in-flight reads, and a FWFT buffer towards decode.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [2:0]  redir_npc_op,
    input  logic [31:0] redir_pc,
    input  logic [31:0] redir_imm,
    input  logic [31:0] redir_rs,
    input  logic        redir_taken,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_adel
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d, disc_q, disc_d;
    logic          adel_pend_q, adel_pend_d;
    logic [AW-1:0] tag_wr_q, tag_rd_q;
    fetch_tag_t    tag_mem_q [DEPTH];
    fetch_tag_t    tag_head;

    redir_t        redir;
    logic          issue, drop;
    logic          fifo_push, fifo_pop, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_in, fifo_out;

    // Redirect resolution; a redirect that takes blocks issue in its own cycle.
    always_comb begin
        redir = '0;
        if (redir_valid) redir = npc_resolve(redir_npc_op, redir_pc, redir_imm, redir_rs, redir_taken);
    end

    assign imem_req  = rst_n && !redir.take &&
                       ((SW'(outst_q) + SW'(fifo_count)) < SW'(DEPTH));
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;
    assign drop      = imem_rvalid && (disc_q != '0);
    assign fifo_push = imem_rvalid && !drop;
    assign fifo_pop  = inst_valid && inst_ready;
    assign tag_head  = tag_mem_q[tag_rd_q];
    assign fifo_in   = '{adel: tag_head.adel, pc: tag_head.pc, inst: imem_rdata};

    always_comb begin
        outst_d     = outst_q + CW'(issue) - CW'(imem_rvalid);
        disc_d      = disc_q - CW'(drop);
        pc_d        = pc_q;
        adel_pend_d = adel_pend_q;
        if (issue) begin
            pc_d        = pc_q + 32'd4;
            adel_pend_d = 1'b0;
        end
        // Everything still outstanding after a redirect belongs to the old stream.
        if (redir.take) begin
            disc_d      = outst_d;
            pc_d        = redir.target;
            adel_pend_d = redir.adel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            outst_q     <= '0;
            disc_q      <= '0;
            adel_pend_q <= 1'b0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            outst_q     <= outst_d;
            disc_q      <= disc_d;
            adel_pend_q <= adel_pend_d;
            if (issue)       tag_wr_q <= tag_wr_q + AW'(1);
            if (imem_rvalid) tag_rd_q <= tag_rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) tag_mem_q[tag_wr_q] <= '{adel: adel_pend_q, pc: pc_q};
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redir.take),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_out),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_out.inst;
    assign inst_pc    = fifo_out.pc;
    assign inst_adel  = fifo_out.adel;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory model, expected-stream scoreboard, redirect table, reset cases.
module tb_ifetch_unit;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hBFC0_0000;

    logic        clk, rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redir_valid, redir_taken;
    logic [2:0]  redir_npc_op;
    logic [31:0] redir_pc, redir_imm, redir_rs;
    logic        inst_valid, inst_ready, inst_adel;
    logic [31:0] inst, inst_pc;

    ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redir_valid(redir_valid), .redir_npc_op(redir_npc_op), .redir_pc(redir_pc),
        .redir_imm(redir_imm), .redir_rs(redir_rs), .redir_taken(redir_taken),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_adel(inst_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic adel; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        logic [2:0] op; logic [31:0] pc; logic [31:0] imm; logic [31:0] rs; logic taken;
        logic act; logic [31:0] tgt; logic adel;
    } vec_t;

    int checks = 0;
    int errors = 0;
    exp_t  exp_q[$];
    mreq_t mem_q[$];
    logic [31:0] model_pc;
    logic        model_adel;
    int cyc = 0;
    int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    logic rst_drv;
    logic rd_pend, rd_taken, rd_use_exp, rd_exp_act, rd_exp_adel;
    logic [2:0]  rd_op;
    logic [31:0] rd_pc, rd_imm, rd_rs, rd_exp_tgt;
    int handoffs, first_ho;
    logic        prev_stall, prev_adel;
    logic [31:0] prev_pc, prev_inst;
    vec_t vecs[9];
    logic [2:0] ops[5];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void bench_target(input logic [2:0] op, input logic [31:0] pc,
                                         input logic [31:0] imm, input logic [31:0] rs,
                                         input logic tk, output logic take,
                                         output logic [31:0] tgt, output logic adel);
        take = 1'b0; tgt = 32'h0; adel = 1'b0;
        if (op == 3'b010 && tk) begin
            take = 1'b1; tgt = pc + 32'd4 + imm * 32'd4;
        end else if (op == 3'b011) begin
            take = 1'b1; tgt = ((pc + 32'd4) & 32'hF000_0000) | ((imm & 32'h03FF_FFFF) << 2);
        end else if (op == 3'b100) begin
            take = 1'b1; tgt = rs & 32'hFFFF_FFFC; adel = (rs[1:0] != 2'b00);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{model_pc, word_of(model_pc), model_adel});
            model_pc   = model_pc + 32'd4;
            model_adel = 1'b0;
        end
    endtask

    task automatic model_redirect(input logic [31:0] tgt, input logic adel);
        exp_q.delete();
        model_pc   = tgt;
        model_adel = adel;
        refill();
    endtask

    task automatic sample();
        exp_t e;
        logic take, tadel;
        logic [31:0] tgt;
        if (!rst_n) begin
            mem_q.delete();
            model_redirect(RPC, 1'b0);
            prev_stall = 1'b0;
            return;
        end
        if (dut.fifo_push) check("fifo_overflow", 32'(dut.fifo_count == 3'(DEPTH)), 32'd0);
        if (prev_stall) begin
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_pc", inst_pc, prev_pc);
            check("stall_inst", inst, prev_inst);
            check("stall_adel", 32'(inst_adel), 32'(prev_adel));
        end
        if (inst_valid && inst_ready) begin
            handoffs++;
            if (first_ho < 0) first_ho = cyc;
            refill();
            e = exp_q.pop_front();
            check("handoff_pc", inst_pc, e.pc);
            check("handoff_inst", inst, e.inst);
            check("handoff_adel", 32'(inst_adel), 32'(e.adel));
            refill();
        end
        if (imem_req && imem_gnt)
            mem_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        if (imem_rvalid) void'(mem_q.pop_front());
        take = 1'b0;
        if (redir_valid) begin
            if (rd_use_exp) begin
                take = rd_exp_act; tgt = rd_exp_tgt; tadel = rd_exp_adel;
            end else begin
                bench_target(redir_npc_op, redir_pc, redir_imm, redir_rs, redir_taken, take, tgt, tadel);
            end
            if (take) begin
                check("redir_req_low", 32'(imem_req), 32'd0);
                model_redirect(tgt, tadel);
            end
        end
        prev_stall = inst_valid && !inst_ready && !take;
        prev_pc    = inst_pc;
        prev_inst  = inst;
        prev_adel  = inst_adel;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        rst_n        = rst_drv;
        imem_gnt     = ($urandom_range(99) < gnt_pct);
        inst_ready   = ($urandom_range(99) < rdy_pct);
        redir_valid  = rd_pend;
        redir_npc_op = rd_op;
        redir_pc     = rd_pc;
        redir_imm    = rd_imm;
        redir_rs     = rd_rs;
        redir_taken  = rd_taken;
        if (rst_drv && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        sample();
        rd_pend = 1'b0;
    endtask

    task automatic set_redir(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] rs, input logic tk);
        rd_pend = 1'b1; rd_op = op; rd_pc = pc; rd_imm = imm; rd_rs = rs; rd_taken = tk;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; rst_drv = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redir_valid = 1'b0; redir_npc_op = '0; redir_pc = '0; redir_imm = '0; redir_rs = '0;
        redir_taken = 1'b0; inst_ready = 1'b0;
        rd_pend = 1'b0; rd_use_exp = 1'b0; rd_op = '0; rd_pc = '0; rd_imm = '0; rd_rs = '0;
        rd_taken = 1'b0; rd_exp_act = 1'b0; rd_exp_tgt = '0; rd_exp_adel = 1'b0;
        prev_stall = 1'b0; prev_pc = '0; prev_inst = '0; prev_adel = 1'b0;
        model_pc = RPC; model_adel = 1'b0;
        handoffs = 0; first_ho = -1;
        ops = '{NPC_PC4, NPC_B, NPC_J, NPC_JR, 3'b111};

        vecs[0] = '{NPC_B,   32'hBFC0_0010, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b1, 32'hBFC0_0004, 1'b0};
        vecs[1] = '{NPC_J,   32'hBFC0_0020, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'hB000_0400, 1'b0};
        vecs[2] = '{NPC_JR,  32'h0,         32'h0,         32'h8000_0003, 1'b0, 1'b1, 32'h8000_0000, 1'b1};
        vecs[3] = '{NPC_B,   32'h1000_0000, 32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vecs[4] = '{NPC_PC4, 32'h1000_0000, 32'h0000_0100, 32'h4000_0000, 1'b1, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{3'b111,  32'h1000_0000, 32'h0000_0100, 32'h4000_0000, 1'b1, 1'b0, 32'h0,         1'b0};
        vecs[6] = '{NPC_B,   32'hFFFF_FFF8, 32'h0000_0001, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[7] = '{NPC_JR,  32'h0,         32'h0,         32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000, 1'b0};
        vecs[8] = '{NPC_J,   32'h7FFF_FFFC, 32'h03FF_FFFF, 32'h0,         1'b0, 1'b1, 32'h8FFF_FFFC, 1'b0};

        // Reset then steady streaming, one instruction per cycle
        repeat (2) step();
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_valid", 32'(inst_valid), 32'd0);
        check("reset_addr", imem_addr, RPC);
        rst_drv = 1'b1;
        handoffs = 0; first_ho = -1; base = cyc + 1;
        repeat (12) step();
        check("t1_handoffs", 32'(handoffs), 32'd10);
        check("t1_first_latency", 32'(first_ho - base), 32'd2);

        // Decode stall fills the buffer exactly
        rdy_pct = 0;
        repeat (10) step();
        check("t2_req_dropped", 32'(imem_req), 32'd0);
        gnt_pct = 0; rdy_pct = 100; handoffs = 0;
        repeat (8) step();
        check("t2_buffered", 32'(handoffs), 32'(DEPTH));
        gnt_pct = 100;

        // Redirect target table
        lat_min = 2; lat_max = 3;
        for (int i = 0; i < 9; i++) begin
            repeat (4) step();
            set_redir(vecs[i].op, vecs[i].pc, vecs[i].imm, vecs[i].rs, vecs[i].taken);
            rd_use_exp = 1'b1; rd_exp_act = vecs[i].act; rd_exp_tgt = vecs[i].tgt; rd_exp_adel = vecs[i].adel;
            step();
            rd_use_exp = 1'b0; handoffs = 0;
            repeat (10) step();
            check("tbl_progress", 32'(handoffs > 0), 32'd1);
        end

        // Back-to-back redirects: the later one wins
        repeat (4) step();
        set_redir(NPC_J, 32'hBFC0_0020, 32'h0000_0100, 32'h0, 1'b0);
        step();
        set_redir(NPC_JR, 32'h0, 32'h0, 32'h2000_0002, 1'b0);
        step();
        repeat (12) step();

        // Random gnt, latency, ready and redirects
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 5;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 6)
                set_redir(ops[$urandom_range(4)], $urandom, $urandom, $urandom, 1'($urandom_range(1)));
            step();
        end

        // Reset in the middle of a burst with reads in flight
        gnt_pct = 100; rdy_pct = 100; lat_min = 5; lat_max = 5;
        repeat (3) step();
        rst_drv = 1'b0;
        step();
        step();
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_valid", 32'(inst_valid), 32'd0);
        check("t6_adel", 32'(inst_adel), 32'd0);
        check("t6_addr", imem_addr, RPC);
        rst_drv = 1'b1; lat_min = 1; lat_max = 1; handoffs = 0;
        repeat (10) step();
        check("t6_refetch", 32'(handoffs > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
